rnd_dispenser: RTL and testbench
================================

Name: rnd_dispenser

Overview:
- Consumer end of the 13-bit LFSR random stream.
- Samples the free-running `rnd` word every cycle and splits it into a target-LP field and a delay field.
- Rejects target-LP values outside range and serves random event parameters to NUM_CORES simulation cores through a round-robin req/gnt handshake.
- Also watches the stream for a stuck or zero LFSR and raises a sticky fault.

Parameters:
- NUM_CORES, 4, number of requesting cores.
- NUM_LP, 100, valid target LP ids are 0..NUM_LP-1; must be <= 128.
- MIN_DELAY, 1, constant added to the random delay field.
- TIME_W, 16, width of the delay output.
- STUCK_LIMIT, 4, number of consecutive unchanged samples that trips the fault.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; the block is held in reset while reset==0.
- rnd  in  13  LFSR output, new value each cycle.
- req  in  NUM_CORES  level request per core; held until the matching gnt bit is seen.
- gnt  out  NUM_CORES  one-hot, one-cycle grant pulse, registered.
- out_lp  out  7  target LP id; valid while any gnt bit is high.
- out_delay  out  TIME_W  MIN_DELAY + rnd_q[12:7], zero-extended; valid with gnt.
- rej_cnt  out  8  saturating count of rejected samples, taken in RUN state only.
- lfsr_err  out  1  sticky fault flag.

Behaviour:
- Reset (reset==0 at an edge) clears the following: gnt, out_lp, out_delay, rej_cnt, lfsr_err, rnd_q, stuck_cnt, and the RR pointer (set to core 0). State returns to WARMUP.
  - Reset mid-grant cancels the pulse at that edge.
  - Outputs read 0 during reset.
- Sampling: rnd_q <= rnd every edge, in any non-reset state.
  - LP candidate = rnd_q[6:0].
  - Delay field = rnd_q[12:7].
- FSM has three states:
  - WARMUP: one cycle only (rnd_q not yet valid), then RUN. No grants.
  - RUN: arbitration and checking active.
  - FAULT: entered when lfsr_err sets. No grants; gnt held 0. Exit only via reset.
- Candidate check, in RUN: a candidate is valid iff rnd_q[6:0] < NUM_LP.
  - If any eligible req is high and the candidate is invalid, no grant that edge, and rej_cnt increments, saturating at 255.
  - With no eligible request, invalid samples are not counted.
- Eligibility: req[i] is eligible iff req[i]==1 and gnt[i]==0 in the current cycle. This masks the core that is seeing its grant and has not yet dropped req.
- Grant, in RUN with a valid candidate and at least one eligible request:
  - Choose the first eligible core at or after the RR pointer, wrapping at NUM_CORES-1 -> 0.
  - Next cycle: gnt has that one bit set, out_lp = rnd_q[6:0], out_delay = MIN_DELAY + rnd_q[12:7].
  - The RR pointer moves to grantee+1 (mod NUM_CORES).
  - Otherwise gnt = 0, and out_lp/out_delay hold their last values.
- Latency: a req asserted before edge t, with a valid rnd_q at edge t, gives gnt visible in cycle t+1. At most one grant per cycle.
- Stuck detection, in RUN:
  - stuck_cnt increments on every edge where rnd == rnd_q, and clears otherwise.
  - lfsr_err sets when stuck_cnt reaches STUCK_LIMIT, or immediately on any edge where rnd == 13'd0.
  - lfsr_err is visible the following cycle, and the state goes to FAULT.
  - A grant and a fault on the same edge: the fault wins and gnt stays 0.
- Requesters: must drop req in the cycle after gnt is seen; may re-raise it one cycle later.

Decomposition:
- Package pdes_rnd_pkg holds:
  - RND_W=13.
  - LP field [6:0] and delay field [12:7] position constants.
  - LP_W=7.
  - FSM enum {WARMUP, RUN, FAULT}.
- Sub-module rr_arbiter(NUM_CORES) holds the pointer register and the one-hot pick, with an advance strobe input.
- Field check, stuck logic and output registers stay in rnd_dispenser.

Test Plan (the bench drives rnd directly, not through the LFSR):
1. Basic grant: reset, then rnd=13'd650 (delay 5, lp 10) followed by varying nonzero values; req=4'b0001 → gnt=0001 for exactly one cycle, out_lp=10, out_delay=6, rej_cnt=0.
2. Rejection: lp field=120 for 3 cycles with req=0010 held → no gnt, rej_cnt=3; then lp=99 → gnt=0010, out_lp=99.
3. Round-robin: req=1111, each core drops req after its gnt, valid changing rnd → grants 0001, 0010, 0100, 1000 on consecutive cycles; after re-request the order starts again at 0001.
4. Stuck: rnd held at 650 → lfsr_err=1 after STUCK_LIMIT equal samples; no gnt afterwards even with req=1111; rnd=0 for one cycle → lfsr_err the next cycle.
5. Reset mid-operation: reset=0 while gnt=0100 → gnt, rej_cnt and lfsr_err are 0 the next cycle; after release, WARMUP means the first gnt appears no earlier than 2 cycles later, and the RR pointer restarts at core 0.

Source files
------------

// File: rtl/pdes_rnd_pkg.sv
// Shared constants for the random-event stream: word layout of the LFSR sample
// and the dispenser control states.
package pdes_rnd_pkg;

  localparam int RND_W   = 13;
  localparam int LP_W    = 7;
  localparam int LP_LSB  = 0;
  localparam int LP_MSB  = 6;
  localparam int DLY_LSB = 7;
  localparam int DLY_MSB = 12;
  localparam int DLY_W   = DLY_MSB - DLY_LSB + 1;

  typedef enum logic [1:0] {
    WARMUP,
    RUN,
    FAULT
  } state_t;

endpackage

// File: rtl/rnd_dispenser_rr_arbiter.sv
// Round-robin pick among requesting cores; the pointer only moves when the
// caller confirms that the pick was actually granted.
module rr_arbiter #(
  parameter int NUM_CORES = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] req,
  input  logic                 advance,
  output logic [NUM_CORES-1:0] pick,
  output logic                 found
);

  localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] nxt_ptr;
  int               idx;

  // Scan starts at the pointer so the most recently served core is tried last.
  always_comb begin
    pick    = '0;
    found   = 1'b0;
    nxt_ptr = ptr;
    idx     = 0;
    for (int off = 0; off < NUM_CORES; off++) begin
      idx = (int'(ptr) + off) % NUM_CORES;
      if (!found && req[idx]) begin
        found     = 1'b1;
        pick[idx] = 1'b1;
        nxt_ptr   = PTR_W'((idx + 1) % NUM_CORES);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= nxt_ptr;
    end
  end

endmodule

// File: rtl/rnd_dispenser.sv
// Consumer of the LFSR stream: filters target-LP samples, hands event parameters
// to cores through round-robin req/gnt, and flags a stuck or zero generator.
module rnd_dispenser
  import pdes_rnd_pkg::*;
#(
  parameter int NUM_CORES   = 4,
  parameter int NUM_LP      = 100,
  parameter int MIN_DELAY   = 1,
  parameter int TIME_W      = 16,
  parameter int STUCK_LIMIT = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [RND_W-1:0]     rnd,
  input  logic [NUM_CORES-1:0] req,
  output logic [NUM_CORES-1:0] gnt,
  output logic [LP_W-1:0]      out_lp,
  output logic [TIME_W-1:0]    out_delay,
  output logic [7:0]           rej_cnt,
  output logic                 lfsr_err
);

  localparam int STK_W = $clog2(STUCK_LIMIT + 1);

  state_t               state;
  state_t               nxt_state;
  logic [RND_W-1:0]     rnd_q;
  logic [STK_W-1:0]     stuck_cnt;
  logic [LP_W-1:0]      cand_lp;
  logic [DLY_W-1:0]     cand_dly;
  logic                 cand_ok;
  logic                 run;
  logic                 same;
  logic                 fault_hit;
  logic                 do_grant;
  logic                 do_rej;
  logic                 found;
  logic [NUM_CORES-1:0] eligible;
  logic [NUM_CORES-1:0] pick;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [TIME_W-1:0] delay_of(input logic [DLY_W-1:0] f);
    return TIME_W'(MIN_DELAY) + TIME_W'(f);
  endfunction

  assign cand_lp  = rnd_q[LP_MSB:LP_LSB];
  assign cand_dly = rnd_q[DLY_MSB:DLY_LSB];
  assign cand_ok  = (int'(cand_lp) < NUM_LP);
  assign run      = (state == RUN);
  // A core still looking at its grant pulse must not win a second time.
  assign eligible = req & ~gnt;
  assign same     = (rnd == rnd_q);
  assign fault_hit = run && ((same && (int'(stuck_cnt) + 1 >= STUCK_LIMIT)) || (rnd == '0));
  assign do_grant = run && found && cand_ok && !fault_hit;
  assign do_rej   = run && found && !cand_ok;

  rr_arbiter #(
    .NUM_CORES(NUM_CORES)
  ) u_arb (
    .clock  (clock),
    .reset  (reset),
    .req    (eligible),
    .advance(do_grant),
    .pick   (pick),
    .found  (found)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= WARMUP;
    end else begin
      state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      WARMUP:  nxt_state = RUN;
      RUN:     if (fault_hit) nxt_state = FAULT;
      FAULT:   nxt_state = FAULT;
      default: nxt_state = WARMUP;
    endcase
  end

  // Output register stage: grant pulse, event parameters, reject and fault bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      rnd_q     <= '0;
      stuck_cnt <= '0;
      gnt       <= '0;
      out_lp    <= '0;
      out_delay <= '0;
      rej_cnt   <= '0;
      lfsr_err  <= 1'b0;
    end else begin
      rnd_q <= rnd;
      gnt   <= do_grant ? pick : '0;
      if (do_grant) begin
        out_lp    <= cand_lp;
        out_delay <= delay_of(cand_dly);
      end
      if (do_rej) begin
        rej_cnt <= sat_inc8(rej_cnt);
      end
      if (run) begin
        stuck_cnt <= same ? stuck_cnt + 1'b1 : '0;
      end
      if (fault_hit) begin
        lfsr_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rnd_dispenser.sv
// Bench for rnd_dispenser: directed scenarios plus randomized traffic, every
// cycle compared against an event-level model of the dispenser rules.
module tb_rnd_dispenser;

  localparam int NUM_CORES   = 4;
  localparam int NUM_LP      = 100;
  localparam int MIN_DELAY   = 1;
  localparam int TIME_W      = 16;
  localparam int STUCK_LIMIT = 4;

  logic                 clock;
  logic                 reset;
  logic [12:0]          rnd;
  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] gnt;
  logic [6:0]           out_lp;
  logic [TIME_W-1:0]    out_delay;
  logic [7:0]           rej_cnt;
  logic                 lfsr_err;

  int checks = 0;
  int errors = 0;
  int seq = 0;

  rnd_dispenser #(
    .NUM_CORES  (NUM_CORES),
    .NUM_LP     (NUM_LP),
    .MIN_DELAY  (MIN_DELAY),
    .TIME_W     (TIME_W),
    .STUCK_LIMIT(STUCK_LIMIT)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rnd      (rnd),
    .req      (req),
    .gnt      (gnt),
    .out_lp   (out_lp),
    .out_delay(out_delay),
    .rej_cnt  (rej_cnt),
    .lfsr_err (lfsr_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Event-level model: what the outputs must be after each edge.
  logic [NUM_CORES-1:0] m_gnt;
  logic [6:0]           m_lp;
  logic [TIME_W-1:0]    m_dly;
  int                   m_rej;
  bit                   m_err, m_primed, m_dead, m_valid;
  int                   m_prev, m_same, m_ptr;
  int                   md_lp, md_dl, md_pk;
  logic [NUM_CORES-1:0] md_elig, md_ng;
  bit                   md_bad;

  initial m_valid = 1'b0;

  always @(posedge clock) begin
    if (!reset) begin
      m_gnt = '0; m_lp = '0; m_dly = '0; m_rej = 0; m_err = 0;
      m_primed = 0; m_dead = 0; m_prev = 0; m_same = 0; m_ptr = 0; m_valid = 1;
    end else begin
      md_ng = '0;
      if (m_primed && !m_dead) begin
        md_elig = req & ~m_gnt;
        md_lp   = m_prev % 128;
        md_dl   = m_prev / 128;
        md_bad  = (rnd == 13'd0) || (int'(rnd) == m_prev && m_same + 1 >= STUCK_LIMIT);
        m_same  = (int'(rnd) == m_prev) ? m_same + 1 : 0;
        if (md_elig != 0 && md_lp >= NUM_LP) m_rej = (m_rej < 255) ? m_rej + 1 : 255;
        if (md_bad) begin
          m_err  = 1;
          m_dead = 1;
        end else if (md_elig != 0 && md_lp < NUM_LP) begin
          md_pk = -1;
          for (int k = 0; k < NUM_CORES; k++)
            if (md_pk < 0 && md_elig[(m_ptr + k) % NUM_CORES]) md_pk = (m_ptr + k) % NUM_CORES;
          md_ng[md_pk] = 1'b1;
          m_lp  = 7'(md_lp);
          m_dly = TIME_W'(MIN_DELAY + md_dl);
          m_ptr = (md_pk + 1) % NUM_CORES;
        end
      end
      m_primed = 1;
      m_gnt    = md_ng;
      m_prev   = int'(rnd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    if (m_valid) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("out_lp", 32'(out_lp), 32'(m_lp));
      chk("out_delay", 32'(out_delay), 32'(m_dly));
      chk("rej_cnt", 32'(rej_cnt), 32'(m_rej));
      chk("lfsr_err", 32'(lfsr_err), 32'(m_err));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1 compare_all();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req   = '0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  function automatic logic [12:0] mk(input int d, input int lp);
    return 13'(d * 128 + lp);
  endfunction

  function automatic logic [12:0] nxt();
    logic [12:0] v;
    seq++;
    v = 13'((seq % 64) * 128 + (seq * 7) % NUM_LP);
    if (v == 13'd0 || v == 13'd650) v = v + 13'd1;
    return v;
  endfunction

  int                   rs [NUM_CORES];
  logic [NUM_CORES-1:0] seen, seen_prev;
  logic [12:0]          prev_v, v;
  int                   reps;

  initial begin
    reset = 1'b0;
    req   = '0;
    rnd   = 13'd1;
    repeat (3) tick();
    chk("reset_gnt", 32'(gnt), 32'd0);
    chk("reset_rej", 32'(rej_cnt), 32'd0);
    chk("reset_err", 32'(lfsr_err), 32'd0);

    // Basic grant: 650 = delay 5, lp 10.
    reset = 1'b1; rnd = 13'd650; req = 4'b0001;
    tick();
    chk("warmup_no_gnt", 32'(gnt), 32'd0);
    rnd = nxt();
    tick();
    chk("basic_gnt", 32'(gnt), 32'h1);
    chk("basic_lp", 32'(out_lp), 32'd10);
    chk("basic_delay", 32'(out_delay), 32'd6);
    chk("basic_rej", 32'(rej_cnt), 32'd0);
    chk("model_lp", 32'(m_lp), 32'd10);
    req = '0; rnd = nxt();
    tick();
    chk("basic_one_cycle", 32'(gnt), 32'd0);

    // Rejection of out-of-range LP ids.
    rnd = mk(1, 120); tick();
    rnd = mk(2, 120); tick();
    chk("rej_no_req", 32'(rej_cnt), 32'd0);
    req = 4'b0010;
    rnd = mk(3, 120); tick();
    rnd = mk(4, 120); tick();
    rnd = mk(5, 99);  tick();
    chk("rej_gnt0", 32'(gnt), 32'd0);
    chk("rej_cnt3", 32'(rej_cnt), 32'd3);
    rnd = nxt(); tick();
    chk("rej_then_gnt", 32'(gnt), 32'h2);
    chk("rej_lp99", 32'(out_lp), 32'd99);
    chk("rej_delay", 32'(out_delay), 32'd6);
    req = '0; rnd = nxt(); tick();

    // Reject counter saturation.
    rnd = mk(0, 100); tick();
    req = 4'b0001;
    for (int i = 1; i < 262; i++) begin
      rnd = mk(i % 64, 100 + i % 28);
      tick();
    end
    chk("rej_saturate", 32'(rej_cnt), 32'd255);
    req = '0; rnd = nxt(); tick();

    // Round-robin order from a fresh pointer.
    do_reset();
    req = 4'b1111; rnd = nxt();
    tick();
    seen = '0; seen_prev = '0;
    for (int k = 0; k < 4; k++) begin
      rnd = nxt();
      req = req & ~seen_prev;
      tick();
      chk("rr_order", 32'(gnt), 32'(1 << k));
      seen_prev = seen;
      seen = 4'(1 << k);
    end
    req = req & ~seen_prev; rnd = nxt(); tick();
    chk("rr_masked", 32'(gnt), 32'd0);
    req = req & ~seen; rnd = nxt(); tick();
    req = 4'b1111; rnd = nxt(); tick();
    chk("rr_restart", 32'(gnt), 32'h1);
    req = '0; rnd = nxt(); tick();

    // Stuck generator.
    rnd = 13'd650;
    repeat (STUCK_LIMIT) tick();
    chk("stuck_not_yet", 32'(lfsr_err), 32'd0);
    tick();
    chk("stuck_fault", 32'(lfsr_err), 32'd1);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      rnd = nxt(); tick();
      chk("fault_no_gnt", 32'(gnt), 32'd0);
    end

    // Zero word faults immediately.
    do_reset();
    rnd = nxt(); tick();
    rnd = nxt(); tick();
    chk("zero_pre", 32'(lfsr_err), 32'd0);
    rnd = 13'd0; tick();
    chk("zero_fault", 32'(lfsr_err), 32'd1);

    // Reset in the middle of a grant.
    do_reset();
    rnd = mk(3, 120); tick();
    rnd = mk(4, 7); req = 4'b0100; tick();
    rnd = nxt(); tick();
    chk("mid_gnt", 32'(gnt), 32'h4);
    chk("mid_rej", 32'(rej_cnt), 32'd1);
    chk("mid_delay", 32'(out_delay), 32'd5);
    reset = 1'b0; rnd = nxt(); tick();
    chk("mid_rst_gnt", 32'(gnt), 32'd0);
    chk("mid_rst_rej", 32'(rej_cnt), 32'd0);
    chk("mid_rst_err", 32'(lfsr_err), 32'd0);
    reset = 1'b1; req = 4'b1111; rnd = nxt(); tick();
    chk("post_rst_warmup", 32'(gnt), 32'd0);
    rnd = nxt(); tick();
    chk("post_rst_core0", 32'(gnt), 32'h1);
    req = '0; rnd = nxt(); tick();

    // Randomized traffic with well-behaved requesters.
    do_reset();
    for (int c = 0; c < NUM_CORES; c++) rs[c] = 0;
    prev_v = rnd; reps = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < NUM_CORES; c++) begin
        case (rs[c])
          0:       if ($urandom_range(0, 2) == 0) rs[c] = 1;
          1:       if (gnt[c]) rs[c] = 2;
          default: rs[c] = 0;
        endcase
        req[c] = (rs[c] != 0);
      end
      if ($urandom_range(0, 7) == 0 && reps < 2) begin
        v = prev_v;
        reps++;
      end else begin
        v = 13'($urandom_range(1, 8191));
        while (v == prev_v) v = 13'($urandom_range(1, 8191));
        reps = 0;
      end
      rnd = v; prev_v = v;
      tick();
    end
    req = '0; rnd = 13'd0; tick();
    chk("rand_zero_fault", 32'(lfsr_err), 32'd1);
    rnd = nxt(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
